// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared types and constants for the sound-effect scheduler
package audio_pkg;

  // Scheduler states; RESTART is only reachable when AUDIO_PREEMPT_EN is defined
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PLAY    = 2'd1,
    GAP     = 2'd2,
    RESTART = 2'd3
  } sched_state_t;

  // Clip ids presented to the engine; requester i plays clip i+1
  localparam int CLIP_NONE = 0;
  localparam int CLIP_SFX1 = 1;
  localparam int CLIP_SFX2 = 2;
  localparam int CLIP_SFX3 = 3;

  // Counter width helper that never returns zero (a 1-value counter still needs one bit)
  function automatic int clog2_min1(input int value);
    return ($clog2(value) < 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/audio_prio_picker.sv
// rtl/audio_prio_picker.sv - combinational highest-set-index picker over the pending bits
module audio_prio_picker #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] i_pending,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

  // Ascending scan so the last (highest) set bit wins
  always_comb begin
    o_valid = |i_pending;
    o_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_pending[i]) begin
        o_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/audio_sfx_scheduler.sv
// rtl/audio_sfx_scheduler.sv - arbitrates game sound requests onto one PWM engine; AUDIO_PREEMPT_EN enables preemption
module audio_sfx_scheduler
  import audio_pkg::*;
#(
  parameter int N_REQ          = 3,
  parameter int SEL_W          = 2,
  parameter int GAP_CYCLES     = 1000,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  input  logic             playback_complete,
  output logic             en,
  output logic [SEL_W-1:0] effective_select,
  output logic             busy,
  output logic             timeout_err,
  output logic [N_REQ-1:0] pending
);

  localparam int IDX_W = clog2_min1(N_REQ);
  localparam int WD_W  = clog2_min1(TIMEOUT_CYCLES);
  localparam int GAP_W = clog2_min1(GAP_CYCLES);

  sched_state_t     r_state;
  sched_state_t     w_next_state;
  logic [N_REQ-1:0] r_pending;
  logic [SEL_W-1:0] r_sel;
  logic             r_en;
  logic             r_busy;
  logic             r_timeout_err;
  logic [WD_W-1:0]  r_wd;
  logic [GAP_W-1:0] r_gap;

  logic [N_REQ-1:0] w_pending_d;
  logic [SEL_W-1:0] w_sel_d;
  logic             w_en_d;
  logic             w_timeout_err_d;
  logic [WD_W-1:0]  w_wd_d;
  logic [GAP_W-1:0] w_gap_d;

  logic             w_pick_valid;
  logic [IDX_W-1:0] w_pick_idx;
  logic             w_wd_limit;

`ifdef AUDIO_PREEMPT_EN
  logic [IDX_W-1:0] r_cur_idx;
  logic [IDX_W-1:0] w_cur_idx_d;
  logic             w_preempt;
`endif

  audio_prio_picker #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_pending (r_pending),
    .o_valid   (w_pick_valid),
    .o_idx     (w_pick_idx)
  );

  assign w_wd_limit = (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

`ifdef AUDIO_PREEMPT_EN
  assign w_preempt = (r_state == PLAY) && w_pick_valid && (w_pick_idx > r_cur_idx);
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decision; preemption outranks completion and timeout in the same cycle
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_valid) w_next_state = PLAY;
      end
      PLAY: begin
`ifdef AUDIO_PREEMPT_EN
        if (w_preempt) w_next_state = RESTART;
        else
`endif
        if (playback_complete || w_wd_limit) w_next_state = GAP;
      end
      GAP: begin
        if (r_gap == '0) w_next_state = IDLE;
      end
`ifdef AUDIO_PREEMPT_EN
      RESTART: begin
        w_next_state = w_pick_valid ? PLAY : IDLE;
      end
`endif
      default: w_next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs and counters; grant clears beat new sets
  always_comb begin
    w_pending_d     = r_pending | req;
    w_sel_d         = r_sel;
    w_en_d          = r_en;
    w_timeout_err_d = 1'b0;
    w_wd_d          = r_wd;
    w_gap_d         = r_gap;
`ifdef AUDIO_PREEMPT_EN
    w_cur_idx_d     = r_cur_idx;
`endif
    case (r_state)
`ifdef AUDIO_PREEMPT_EN
      IDLE, RESTART: begin
`else
      IDLE: begin
`endif
        if (w_pick_valid) begin
          w_en_d                  = 1'b1;
          w_sel_d                 = SEL_W'(w_pick_idx) + SEL_W'(1);
          w_pending_d[w_pick_idx] = 1'b0;
          w_wd_d                  = '0;
`ifdef AUDIO_PREEMPT_EN
          w_cur_idx_d             = w_pick_idx;
`endif
        end else begin
          w_en_d  = 1'b0;
          w_sel_d = SEL_W'(CLIP_NONE);
        end
      end
      PLAY: begin
        if (w_next_state == GAP) begin
          w_en_d          = 1'b0;
          w_sel_d         = SEL_W'(CLIP_NONE);
          w_gap_d         = GAP_W'(GAP_CYCLES - 1);
          w_timeout_err_d = !playback_complete;
        end
`ifdef AUDIO_PREEMPT_EN
        else if (w_next_state == RESTART) begin
          // Select held so the engine only sees an enable drop
          w_en_d = 1'b0;
        end
`endif
        else begin
          // Only reached below the limit, so the watchdog cannot wrap
          w_wd_d = r_wd + WD_W'(1);
        end
      end
      GAP: begin
        w_en_d = 1'b0;
        if (r_gap != '0) w_gap_d = r_gap - GAP_W'(1);
      end
      default: begin
        w_en_d  = 1'b0;
        w_sel_d = SEL_W'(CLIP_NONE);
      end
    endcase
  end

  // Output and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pending     <= '0;
      r_sel         <= SEL_W'(CLIP_NONE);
      r_en          <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_wd          <= '0;
      r_gap         <= '0;
`ifdef AUDIO_PREEMPT_EN
      r_cur_idx     <= '0;
`endif
    end else begin
      r_pending     <= w_pending_d;
      r_sel         <= w_sel_d;
      r_en          <= w_en_d;
      r_busy        <= (w_next_state != IDLE);
      r_timeout_err <= w_timeout_err_d;
      r_wd          <= w_wd_d;
      r_gap         <= w_gap_d;
`ifdef AUDIO_PREEMPT_EN
      r_cur_idx     <= w_cur_idx_d;
`endif
    end
  end

  assign en               = r_en;
  assign effective_select = r_sel;
  assign busy             = r_busy;
  assign timeout_err      = r_timeout_err;
  assign pending          = r_pending;

endmodule

// File: tb/tb_audio_sfx_scheduler.sv
// tb/tb_audio_sfx_scheduler.sv - self-checking bench: vector table, corner sequences, randomized model comparison
module tb_audio_sfx_scheduler;

  localparam int NR  = 3;
  localparam int SW  = 2;
  localparam int GAP = 4;
  localparam int TO  = 20;

  localparam int M_IDLE    = 0;
  localparam int M_PLAY    = 1;
  localparam int M_GAP     = 2;
  localparam int M_RESTART = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic          pc = 1'b0;
  logic          en;
  logic [SW-1:0] effective_select;
  logic          busy;
  logic          timeout_err;
  logic [NR-1:0] pending;

  int n_checks = 0;
  int n_fail   = 0;

  audio_sfx_scheduler #(
    .N_REQ          (NR),
    .SEL_W          (SW),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req               (req),
    .playback_complete (pc),
    .en                (en),
    .effective_select  (effective_select),
    .busy              (busy),
    .timeout_err       (timeout_err),
    .pending           (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] req;
    logic       pc;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[$];

  // Observation word: {en, select[1:0], busy, timeout_err, pending[2:0]}
  function automatic logic [7:0] obs();
    return {en, effective_select, busy, timeout_err, pending};
  endfunction

  function automatic vec_t mk(input logic [2:0] r, input logic c, input logic e,
                              input logic [1:0] s, input logic b, input logic [2:0] p);
    vec_t v;
    v.req = r;
    v.pc  = c;
    v.exp = {e, s, b, 1'b0, p};
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    req = '0;
    pc  = 1'b0;
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  // Reference model: a clip plays until done or TO cycles, then GAP silent cycles
  int       m_phase;
  int       m_clip;
  int       m_age;
  int       m_gap_left;
  bit       m_terr;
  bit [2:0] m_pend;

  function automatic int highest(input bit [2:0] p);
    for (int i = 2; i >= 0; i--) if (p[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = M_IDLE; m_clip = 0; m_age = 0; m_gap_left = 0; m_terr = 0; m_pend = '0;
  endtask

  task automatic model_step(input bit [2:0] r, input bit c);
    bit [2:0] np;
    int       h;
    np = m_pend | r;
    h = highest(m_pend);
    m_terr = 0;
    case (m_phase)
      M_IDLE, M_RESTART: begin
        if (h >= 0) begin
          m_clip = h + 1; np[h] = 0; m_phase = M_PLAY; m_age = 0;
        end else begin
          m_clip = 0; m_phase = M_IDLE;
        end
      end
      M_PLAY: begin
`ifdef AUDIO_PREEMPT_EN
        if (h + 1 > m_clip) m_phase = M_RESTART;
        else
`endif
        if (c || m_age == TO - 1) begin
          m_terr = !c; m_phase = M_GAP; m_clip = 0; m_gap_left = GAP;
        end else begin
          m_age++;
        end
      end
      default: begin
        m_gap_left--;
        if (m_gap_left == 0) m_phase = M_IDLE;
      end
    endcase
    m_pend = np;
  endtask

  function automatic logic [7:0] model_exp();
    logic       e;
    logic [1:0] s;
    e = (m_phase == M_PLAY);
    s = (m_phase == M_PLAY || m_phase == M_RESTART) ? 2'(m_clip) : 2'd0;
    return {e, s, logic'(m_phase != M_IDLE), logic'(m_terr), m_pend};
  endfunction

  initial begin
    int en_cnt;
    int te_cnt;

    // Reset state while reset is held
    @(negedge clk);
    @(negedge clk);
    check("rst_state", 32'(obs()), 32'h0);
    reset_n = 1'b1;

    // Vector table: inputs before an edge, outputs after it
    vt.push_back(mk(3'b001, 0, 0, 2'd0, 0, 3'b001));
    vt.push_back(mk(3'b000, 0, 1, 2'd1, 1, 3'b000));
    vt.push_back(mk(3'b000, 0, 1, 2'd1, 1, 3'b000));
    vt.push_back(mk(3'b000, 1, 0, 2'd0, 1, 3'b000));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 1, 3'b000));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 1, 3'b000));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 1, 3'b000));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 0, 3'b000));
    vt.push_back(mk(3'b011, 0, 0, 2'd0, 0, 3'b011));
    vt.push_back(mk(3'b000, 0, 1, 2'd2, 1, 3'b001));
    vt.push_back(mk(3'b000, 1, 0, 2'd0, 1, 3'b001));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 1, 3'b001));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 1, 3'b001));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 1, 3'b001));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 0, 3'b001));
    vt.push_back(mk(3'b000, 0, 1, 2'd1, 1, 3'b000));
    vt.push_back(mk(3'b001, 0, 1, 2'd1, 1, 3'b001));
    vt.push_back(mk(3'b001, 0, 1, 2'd1, 1, 3'b001));
    vt.push_back(mk(3'b001, 1, 0, 2'd0, 1, 3'b001));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 1, 3'b001));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 1, 3'b001));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 1, 3'b001));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 0, 3'b001));
    vt.push_back(mk(3'b000, 0, 1, 2'd1, 1, 3'b000));
    vt.push_back(mk(3'b000, 1, 0, 2'd0, 1, 3'b000));
    vt.push_back(mk(3'b000, 1, 0, 2'd0, 1, 3'b000));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 1, 3'b000));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 1, 3'b000));
    vt.push_back(mk(3'b000, 0, 0, 2'd0, 0, 3'b000));
    vt.push_back(mk(3'b000, 1, 0, 2'd0, 0, 3'b000));

    foreach (vt[i]) begin
      req = vt[i].req;
      pc  = vt[i].pc;
      step();
      check($sformatf("vec%0d", i), 32'(obs()), 32'(vt[i].exp));
    end
    req = '0;
    pc  = 1'b0;

    // Watchdog: completion never arrives
    do_reset();
    req = 3'b100;
    step();
    req = '0;
    en_cnt = 0;
    te_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (en) en_cnt++;
      if (timeout_err) begin
        te_cnt++;
        check("to_en_low", 32'(en), 32'd0);
        check("to_busy_gap", 32'(busy), 32'd1);
      end
    end
    check("to_en_cycles", 32'(en_cnt), 32'd20);
    check("to_err_pulses", 32'(te_cnt), 32'd1);
    check("to_back_idle", 32'(busy), 32'd0);

    // Higher-priority request arriving while clip 1 plays
    do_reset();
    req = 3'b001;
    step();
    req = '0;
    step();
    check("pre_play1", 32'({en, effective_select}), 32'({1'b1, 2'd1}));
    req = 3'b100;
    step();
    req = '0;
    check("pre_latched", 32'({en, pending}), 32'({1'b1, 3'b100}));
    step();
`ifdef AUDIO_PREEMPT_EN
    check("pre_restart", 32'({en, effective_select, busy}), 32'({1'b0, 2'd1, 1'b1}));
    step();
    check("pre_play3", 32'({en, effective_select, pending}), 32'({1'b1, 2'd3, 3'b000}));
    pc = 1'b1;
    step();
    pc = 1'b0;
    repeat (4) step();
    check("pre_idle", 32'(busy), 32'd0);
    step();
    check("pre_no_replay", 32'({en, pending}), 32'd0);
`else
    check("nopre_wait", 32'({en, effective_select, pending}), 32'({1'b1, 2'd1, 3'b100}));
    pc = 1'b1;
    step();
    pc = 1'b0;
    check("nopre_gap", 32'({en, pending}), 32'({1'b0, 3'b100}));
    repeat (4) step();
    check("nopre_idle", 32'({busy, pending}), 32'({1'b0, 3'b100}));
    step();
    check("nopre_play3", 32'({en, effective_select, pending}), 32'({1'b1, 2'd3, 3'b000}));
`endif

    // Asynchronous reset in the middle of a clip
    do_reset();
    req = 3'b001;
    step();
    req = 3'b000;
    step();
    req = 3'b010;
    step();
    req = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_async", 32'({en, effective_select, busy}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("rst_after", 32'(obs()), 32'd0);

    // Randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int i = 0; i < 3000; i++) begin
      check("rand", 32'(obs()), 32'(model_exp()));
      req = 3'b000;
      for (int b = 0; b < 3; b++) req[b] = ($urandom_range(15) == 0);
      pc = ($urandom_range(7) == 0);
      model_step(req, pc);
      step();
    end
    check("rand_last", 32'(obs()), 32'(model_exp()));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
